// File: rtl/time_set_ctrl.sv
// time_set_ctrl: push-button time editor for the digital clock.
// Debounces three buttons, steps an edit FSM through H/M/S fields and drives load and blink blanks.

// One button lane: 2-FF synchronizer, stability-count debounce, rising-edge press strobe.
module time_set_btn #(
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int CNT_W        = 29
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic             sync1, sync2, level;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == DB_LAST) begin
                // Level accepted; only a 0->1 acceptance produces a press.
                cnt   <= '0;
                level <= sync2;
                press <= sync2;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end
endmodule

module time_set_ctrl #(
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int BLINK_CYC    = 12_500_000,
    parameter int TIMEOUT_CYC  = 500_000_000,
    parameter int CNT_W        = 29
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_next,
    input  logic       btn_inc,
    input  logic [4:0] cur_hour,
    input  logic [2:0] cur_min10,
    input  logic [3:0] cur_min1,
    input  logic [2:0] cur_sec10,
    input  logic [3:0] cur_sec1,
    output logic [4:0] set_hour,
    output logic [2:0] set_min10,
    output logic [3:0] set_min1,
    output logic [2:0] set_sec10,
    output logic [3:0] set_sec1,
    output logic       load,
    output logic       editing,
    output logic       blank_hour,
    output logic       blank_min,
    output logic       blank_sec
);
    localparam int               NUM_BTN    = 3;
    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_CYC - 1);
    localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYC - 1);

    typedef struct packed {
        logic [4:0] hour;
        logic [2:0] min10;
        logic [3:0] min1;
        logic [2:0] sec10;
        logic [3:0] sec1;
    } hms_t;

    typedef enum logic [2:0] {IDLE, SET_HOUR, SET_MIN, SET_SEC, COMMIT} state_t;

    state_t             state, state_nx;
    hms_t               edit;
    logic [NUM_BTN-1:0] btn_raw, press;
    logic               p_mode, p_next, p_inc, pulse;
    logic               in_set, state_chg, phase;
    logic [CNT_W-1:0]   blink_cnt, to_cnt;

    assign btn_raw = {btn_inc, btn_next, btn_mode};

    generate
        for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
            time_set_btn #(
                .DEBOUNCE_CYC(DEBOUNCE_CYC),
                .CNT_W       (CNT_W)
            ) u_btn (
                .clk  (clk),
                .reset(reset),
                .btn  (btn_raw[i]),
                .press(press[i])
            );
        end
    endgenerate

    // Same-cycle presses resolve mode > next > inc; losers are dropped.
    assign p_mode = press[0];
    assign p_next = press[1] & ~press[0];
    assign p_inc  = press[2] & ~press[1] & ~press[0];
    assign pulse  = |press;

    function automatic logic [4:0] hour_inc(input logic [4:0] h);
        return (h >= 5'd23) ? 5'd0 : h + 5'd1;
    endfunction

    // BCD pair {tens[2:0], units[3:0]} counting 00..59; no carry leaves the pair.
    function automatic logic [6:0] bcd_inc(input logic [6:0] v);
        logic [2:0] tens;
        logic [3:0] units;
        tens  = v[6:4];
        units = v[3:0];
        if (units >= 4'd9) begin
            units = 4'd0;
            tens  = (tens >= 3'd5) ? 3'd0 : tens + 3'd1;
        end else begin
            units = units + 4'd1;
        end
        return {tens, units};
    endfunction

    assign in_set    = (state == SET_HOUR) || (state == SET_MIN) || (state == SET_SEC);
    assign state_chg = (state_nx != state);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        load       = 1'b0;
        editing    = 1'b1;
        blank_hour = 1'b0;
        blank_min  = 1'b0;
        blank_sec  = 1'b0;
        case (state)
            IDLE: begin
                editing = 1'b0;
                if (p_mode) state_nx = SET_HOUR;
            end
            SET_HOUR, SET_MIN, SET_SEC: begin
                blank_hour = (state == SET_HOUR) & phase;
                blank_min  = (state == SET_MIN)  & phase;
                blank_sec  = (state == SET_SEC)  & phase;
                if (p_mode) begin
                    state_nx = COMMIT;
                end else if (p_next) begin
                    case (state)
                        SET_HOUR: state_nx = SET_MIN;
                        SET_MIN:  state_nx = SET_SEC;
                        default:  state_nx = SET_HOUR;
                    endcase
                end else if (!p_inc && to_cnt == TO_LAST) begin
                    state_nx = IDLE;
                end
            end
            COMMIT: begin
                load     = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                editing  = 1'b0;
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            edit <= '0;
        end else if (state == IDLE && p_mode) begin
            edit <= {cur_hour, cur_min10, cur_min1, cur_sec10, cur_sec1};
        end else if (p_inc) begin
            case (state)
                SET_HOUR: edit.hour <= hour_inc(edit.hour);
                SET_MIN:  {edit.min10, edit.min1} <= bcd_inc({edit.min10, edit.min1});
                SET_SEC:  {edit.sec10, edit.sec1} <= bcd_inc({edit.sec10, edit.sec1});
                default:  ;
            endcase
        end
    end

    // Idle timeout: restarts on any press and on every state change.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                               to_cnt <= '0;
        else if (!in_set || state_chg || pulse)   to_cnt <= '0;
        else                                      to_cnt <= to_cnt + CNT_W'(1);
    end

    // Blink phase restarts dark-free (phase 0) on every entry, field changes included.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (!in_set || state_chg) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            phase     <= ~phase;
        end else begin
            blink_cnt <= blink_cnt + CNT_W'(1);
        end
    end

    assign set_hour  = edit.hour;
    assign set_min10 = edit.min10;
    assign set_min1  = edit.min1;
    assign set_sec10 = edit.sec10;
    assign set_sec1  = edit.sec1;
endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: table-driven edit steps with a load scoreboard,
// plus timed sequences for debounce latency, timeout and blink phase.
`timescale 1ns/1ps
module tb_time_set_ctrl;
    localparam int         DEB = 4, BLK = 8, TMO = 64;
    localparam logic [2:0] M = 3'b001, N = 3'b010, I = 3'b100;

    logic       clk = 1'b0, reset = 1'b0;
    logic       btn_mode = 1'b0, btn_next = 1'b0, btn_inc = 1'b0;
    logic [4:0] cur_hour = '0;
    logic [2:0] cur_min10 = '0, cur_sec10 = '0;
    logic [3:0] cur_min1 = '0, cur_sec1 = '0;
    logic [4:0] set_hour;
    logic [2:0] set_min10, set_sec10;
    logic [3:0] set_min1, set_sec1;
    logic       load, editing, blank_hour, blank_min, blank_sec;

    logic [16:0] set_v;
    logic [2:0]  blank_v;
    assign set_v   = {set_hour, set_min10, set_min1, set_sec10, set_sec1};
    assign blank_v = {blank_hour, blank_min, blank_sec};

    time_set_ctrl #(
        .DEBOUNCE_CYC(DEB), .BLINK_CYC(BLK), .TIMEOUT_CYC(TMO), .CNT_W(8)
    ) dut (
        .clk(clk), .reset(reset),
        .btn_mode(btn_mode), .btn_next(btn_next), .btn_inc(btn_inc),
        .cur_hour(cur_hour), .cur_min10(cur_min10), .cur_min1(cur_min1),
        .cur_sec10(cur_sec10), .cur_sec1(cur_sec1),
        .set_hour(set_hour), .set_min10(set_min10), .set_min1(set_min1),
        .set_sec10(set_sec10), .set_sec1(set_sec1),
        .load(load), .editing(editing),
        .blank_hour(blank_hour), .blank_min(blank_min), .blank_sec(blank_sec)
    );

    always #5 clk = ~clk;

    int n_total = 0, n_pass = 0;
    logic [16:0] sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Every load must match a commit the bench expects, carrying the expected time.
    always @(negedge clk) begin
        if (load) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_load: got load=1 set=%0h expected no load", set_v);
            end else begin
                check("load_set", set_v, sb.pop_front());
            end
        end
    end

    function automatic logic [16:0] hms(input int h, input int m, input int s);
        return {5'(h), 3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10)};
    endfunction

    typedef struct {
        logic [2:0]  mask;
        logic [16:0] cur;
        logic        exp_edit;
        logic [16:0] exp_set;
    } step_t;

    function automatic step_t mk(input logic [2:0] m, input logic [16:0] c,
                                 input logic e, input logic [16:0] x);
        step_t s;
        s.mask = m; s.cur = c; s.exp_edit = e; s.exp_set = x;
        return s;
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic drive_btn(input logic [2:0] m);
        btn_mode = m[0]; btn_next = m[1]; btn_inc = m[2];
    endtask

    task automatic set_cur(input logic [16:0] v);
        {cur_hour, cur_min10, cur_min1, cur_sec10, cur_sec1} = v;
    endtask

    task automatic press(input logic [2:0] m);
        tick(); drive_btn(m);
        repeat (8) tick();
        drive_btn(3'b000);
        repeat (8) tick();
    endtask

    // Returns just after the edge on which the press takes effect (7 edges in).
    task automatic press_to_entry(input logic [2:0] m);
        tick(); drive_btn(m);
        repeat (7) tick();
        drive_btn(3'b000);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before 2ms");
        $fatal(1, "watchdog");
    end

    step_t tbl[22];

    initial begin
        logic prev_edit;
        tbl[0]  = mk(I,     hms(13,47,22), 1'b0, hms(13,47,22));
        tbl[1]  = mk(N,     hms(13,47,22), 1'b0, hms(13,47,22));
        tbl[2]  = mk(M,     hms(23,59,59), 1'b1, hms(23,59,59));
        tbl[3]  = mk(I,     hms(23,59,59), 1'b1, hms( 0,59,59));
        tbl[4]  = mk(N,     hms(23,59,59), 1'b1, hms( 0,59,59));
        tbl[5]  = mk(I,     hms(23,59,59), 1'b1, hms( 0, 0,59));
        tbl[6]  = mk(N,     hms(23,59,59), 1'b1, hms( 0, 0,59));
        tbl[7]  = mk(I,     hms(23,59,59), 1'b1, hms( 0, 0, 0));
        tbl[8]  = mk(M,     hms(23,59,59), 1'b0, hms( 0, 0, 0));
        tbl[9]  = mk(M,     hms( 8,15,30), 1'b1, hms( 8,15,30));
        tbl[10] = mk(I,     hms( 8,15,30), 1'b1, hms( 9,15,30));
        tbl[11] = mk(I,     hms( 8,15,30), 1'b1, hms(10,15,30));
        tbl[12] = mk(M,     hms( 8,15,30), 1'b0, hms(10,15,30));
        tbl[13] = mk(M,     hms( 5,39, 9), 1'b1, hms( 5,39, 9));
        tbl[14] = mk(N | I, hms( 5,39, 9), 1'b1, hms( 5,39, 9));
        tbl[15] = mk(I,     hms( 5,39, 9), 1'b1, hms( 5,40, 9));
        tbl[16] = mk(N,     hms( 5,39, 9), 1'b1, hms( 5,40, 9));
        tbl[17] = mk(I,     hms( 5,39, 9), 1'b1, hms( 5,40,10));
        tbl[18] = mk(N,     hms( 5,39, 9), 1'b1, hms( 5,40,10));
        tbl[19] = mk(I,     hms( 5,39, 9), 1'b1, hms( 6,40,10));
        tbl[20] = mk(N,     hms( 5,39, 9), 1'b1, hms( 6,40,10));
        tbl[21] = mk(M | I, hms( 5,39, 9), 1'b0, hms( 6,40,10));

        // Reset held with buttons toggling
        for (int k = 0; k < 10; k++) begin
            tick(); drive_btn(3'(k));
        end
        check("reset_outputs", {set_v, load, editing, blank_v}, 0);
        drive_btn(3'b000);
        tick(); reset = 1'b1;
        repeat (10) tick();
        check("post_reset_outputs", {set_v, load, editing, blank_v}, 0);

        // Chattering mode button, then a stable press: 2 sync + 4 debounce + 1 edge
        set_cur(hms(13,47,22));
        for (int k = 0; k < 20; k++) begin
            tick(); btn_mode = ((k / 2) % 2 == 0);
        end
        tick();
        check("chatter_no_edit", editing, 0);
        btn_mode = 1'b1;
        repeat (6) tick();
        check("bounce_edge6", editing, 0);
        tick();
        check("bounce_edge7", editing, 1);
        check("bounce_capture", set_v, hms(13,47,22));
        repeat (30) tick();
        check("hold_single_pulse", editing, 1);
        drive_btn(3'b000);
        repeat (40) tick();
        check("timeout_hour_idle", editing, 0);
        check("timeout_keeps_edit", set_v, hms(13,47,22));

        // Table-driven edit steps
        prev_edit = 1'b0;
        for (int i = 0; i < 22; i++) begin
            set_cur(tbl[i].cur);
            if (tbl[i].mask[0] && prev_edit) sb.push_back(tbl[i].exp_set);
            press(tbl[i].mask);
            check($sformatf("step%0d_editing", i), editing, tbl[i].exp_edit);
            check($sformatf("step%0d_set", i), set_v, tbl[i].exp_set);
            prev_edit = tbl[i].exp_edit;
        end

        // Timeout in SET_SEC after exactly 64 idle cycles
        set_cur(hms(11,22,33));
        press(M); press(N); press_to_entry(N);
        check("sec_entry_editing", editing, 1);
        check("sec_entry_blank", blank_v, 0);
        repeat (63) tick();
        check("timeout_cycle63", editing, 1);
        tick();
        check("timeout_cycle64", editing, 0);
        check("timeout_set_kept", set_v, hms(11,22,33));

        // Blink in SET_MIN, then restart on moving to SET_SEC
        set_cur(hms(7,30,45));
        press(M); press_to_entry(N);
        for (int k = 0; k < 24; k++) begin
            if (k > 0) tick();
            check($sformatf("blink_min_k%0d", k), blank_v, {1'b0, 1'((k / 8) % 2), 1'b0});
        end
        press_to_entry(N);
        for (int k = 0; k < 16; k++) begin
            if (k > 0) tick();
            check($sformatf("blink_sec_k%0d", k), blank_v, {2'b00, 1'((k / 8) % 2)});
        end
        repeat (80) tick();
        check("blink_timeout_idle", {editing, blank_v}, 0);

        check("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
